// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Oversampling asynchronous serial receiver with a small receive FIFO.
// Frames carry 5-8 data bits (chosen per frame), optional even/odd parity
// and one stop bit. Each completed word is queued together with its parity
// and framing error flags. The processor drains the queue with a one-cycle
// read strobe. Everything runs on the single clock clk.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset, clears all state
//   serial_in    raw serial line (idle high), asynchronous to clk
//   data_bits    11=5, 10=6, 01=7, 00=8 data bits (latched at frame start)
//   parity_mode  00/11 none, 01 even, 10 odd (latched at frame start)
//   data_read    one-cycle pop strobe for the FIFO head
//   data_out     FIFO head word, right-justified, zero when empty
//   parity_err   parity error flag of the head entry
//   frame_err    stop-bit error flag of the head entry
//   data_ready   FIFO holds at least one word
//   receiving    receiver is inside a frame (FSM not IDLE)
//   overrun      sticky: a completed word was dropped because FIFO was full
module uart_rx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic [1:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       data_read,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       frame_err,
  output logic       data_ready,
  output logic       receiving,
  output logic       overrun
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic          sync1, s, s_prev;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [2:0]    state;
  logic [SW-1:0] sc;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic [1:0]    cfg_bits;
  logic [1:0]    cfg_par;
  logic          par_en;
  logic [2:0]    last_bit;
  logic          fall;
  logic          sample_now;
  logic          push;
  logic [9:0]    push_word;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, wr_en;
  logic [9:0]    head;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  // All resets to 1 so that reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync1  <= serial_in;
      s      <= sync1;
      s_prev <= s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick     = (tick_cnt == TICK_LAST);
  assign fall     = s_prev & ~s;
  assign par_en   = cfg_par[0] ^ cfg_par[1];
  assign last_bit = 3'd7 - {1'b0, cfg_bits};

  // START samples half a bit after the edge; later states sample one full
  // bit period after the previous sample, which lands on each bit centre.
  assign sample_now = tick && ((state == ST_START) ? (sc == HALF_LAST)
                                                   : (sc == FULL_LAST));

  // Receive FSM. Data bits are written straight into their final position,
  // so short words come out right-justified with zero MSBs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sc       <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      cfg_bits <= '0;
      cfg_par  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            sc       <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            cfg_bits <= data_bits;
            cfg_par  <= parity_mode;
          end
        end
        ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
          if (sample_now) begin
            sc <= '0;
            case (state)
              ST_START: state <= s ? ST_IDLE : ST_DATA;
              ST_DATA: begin
                shreg[bit_cnt] <= s;
                if (bit_cnt == last_bit) begin
                  bit_cnt <= '0;
                  state   <= par_en ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
              ST_PARITY: begin
                par_bad <= (cfg_par == 2'b01) ? ((^shreg) ^ s) : ~((^shreg) ^ s);
                state   <= ST_STOP;
              end
              default: state <= ST_IDLE;
            endcase
          end else if (tick) begin
            sc <= sc + SW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push      = (state == ST_STOP) && sample_now;
  assign push_word = {~s, par_bad, shreg};

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = data_read && !empty;
  // A full FIFO still accepts a word if the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (data_read) overrun <= 1'b0;
      else if (push && full) overrun <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign data_out   = empty ? 8'h00 : head[7:0];
  assign parity_err = empty ? 1'b0 : head[8];
  assign frame_err  = empty ? 1'b0 : head[9];
  assign data_ready = !empty;
  assign receiving  = (state != ST_IDLE);

endmodule
